// File: rtl/reg_file_pkg.sv
// Shared bus constants and types for the integer register file.
package reg_file_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int DATA_BUS     = 32;
  localparam int REG_COUNT    = 32;

  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
  typedef logic [DATA_BUS-1:0]     data_t;

  localparam reg_addr_t ZERO_REG_ADDR = '0;

endpackage

// File: rtl/reg_file.sv
// 32 x 32 register file: one synchronous write port, two combinational read ports
// with same-cycle write-to-read bypass; register 0 is hardwired to zero.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_en_1,
  input  logic [REG_ADDR_BUS-1:0] read_addr_1,
  output logic [DATA_BUS-1:0]     read_data_1,
  input  logic                    read_en_2,
  input  logic [REG_ADDR_BUS-1:0] read_addr_2,
  output logic [DATA_BUS-1:0]     read_data_2,
  input  logic                    write_en,
  input  logic [REG_ADDR_BUS-1:0] write_addr,
  input  logic [DATA_BUS-1:0]     write_data
);

  data_t regs [REG_COUNT];
  logic  write_live;

  // A write is only real out of reset and away from the zero register; both the
  // storage update and the bypass paths key off this single qualifier.
  assign write_live = rst && write_en && (write_addr != ZERO_REG_ADDR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (write_live) begin
      regs[write_addr] <= write_data;
    end
  end

  // Read port priority: reset, disabled port, zero register, bypass, storage.
  always_comb begin
    read_data_1 = '0;
    if (rst && read_en_1 && (read_addr_1 != ZERO_REG_ADDR)) begin
      if (write_live && (write_addr == read_addr_1)) begin
        read_data_1 = write_data;
      end else begin
        read_data_1 = regs[read_addr_1];
      end
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (rst && read_en_2 && (read_addr_2 != ZERO_REG_ADDR)) begin
      if (write_live && (write_addr == read_addr_2)) begin
        read_data_2 = write_data;
      end else begin
        read_data_2 = regs[read_addr_2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed scoreboard bench for reg_file: the driver queues expected read data,
// a negedge monitor pops and compares both read ports.
module tb_reg_file;
  import reg_file_pkg::*;

  logic      clk;
  logic      rst;
  logic      read_en_1, read_en_2, write_en;
  reg_addr_t read_addr_1, read_addr_2, write_addr;
  data_t     read_data_1, read_data_2, write_data;

  logic      chk;
  logic [63:0] exp_q[$];
  string       name_q[$];
  int          n_cmp;
  int          n_bad;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .read_en_1   (read_en_1),
    .read_addr_1 (read_addr_1),
    .read_data_1 (read_data_1),
    .read_en_2   (read_en_2),
    .read_addr_2 (read_addr_2),
    .read_data_2 (read_data_2),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus; when chk_i is set the expected read pair is queued.
  task automatic step(input logic rst_i, input logic we, input reg_addr_t wa,
                      input data_t wd, input logic re1, input reg_addr_t ra1,
                      input logic re2, input reg_addr_t ra2, input logic chk_i,
                      input data_t e1, input data_t e2, input string nm);
    @(posedge clk);
    #1;
    rst = rst_i; write_en = we; write_addr = wa; write_data = wd;
    read_en_1 = re1; read_addr_1 = ra1; read_en_2 = re2; read_addr_2 = ra2;
    if (chk_i) begin
      exp_q.push_back({e1, e2});
      name_q.push_back(nm);
    end
    chk = chk_i;
  endtask

  // Read both ports of one index with no write in flight.
  task automatic rd(input reg_addr_t a, input data_t e, input string nm);
    step(1'b1, 1'b0, '0, '0, 1'b1, a, 1'b1, a, 1'b1, e, e, nm);
  endtask

  task automatic wr(input reg_addr_t a, input data_t d);
    step(1'b1, 1'b1, a, d, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, "");
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expected: output sampled with empty expected queue");
      end else begin
        logic [63:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp += 2;
        if (read_data_1 !== e[63:32]) begin
          n_bad++;
          $display("FAIL %s port1: got %h expected %h", nm, read_data_1, e[63:32]);
        end
        if (read_data_2 !== e[31:0]) begin
          n_bad++;
          $display("FAIL %s port2: got %h expected %h", nm, read_data_2, e[31:0]);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk = 1'b0;
    rst = 1'b0; write_en = 1'b0; write_addr = '0; write_data = '0;
    read_en_1 = 1'b0; read_addr_1 = '0; read_en_2 = 1'b0; read_addr_2 = '0;

    // Reset held two cycles with a write present; reads forced to zero.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 32'h0, 32'h0, "rst_hold_a");
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 32'h0, 32'h0, "rst_hold_b");
    rd(5'd5, 32'h0, "rst_r5");

    // Write/read, including bypass on both ports and a disabled port.
    step(1'b1, 1'b1, 5'd8, 32'h12345678, 1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 32'h12345678, 32'h12345678, "wr_r8_byp");
    rd(5'd8, 32'h12345678, "rd_r8");
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd8, 1'b0, 5'd8, 1'b1, 32'h12345678, 32'h0, "r8_en2_off");

    // Zero register: no bypass, no storage.
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'h0, 32'h0, "wr_r0_byp");
    rd(5'd0, 32'h0, "rd_r0");

    // Bypass on one port while the other reads storage.
    wr(5'd9, 32'h1);
    step(1'b1, 1'b1, 5'd10, 32'h00001010, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 32'h1, 32'h00001010, "r9_store_r10_byp");
    step(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 32'hCAFEF00D, 32'h00001010, "r9_byp");
    rd(5'd9, 32'hCAFEF00D, "r9_after");
    step(1'b1, 1'b1, 5'd9, 32'h55555555, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 32'h0, 32'h55555555, "byp_en1_off");
    rd(5'd9, 32'h55555555, "r9_final");

    // Write-enable gating.
    step(1'b1, 1'b0, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 32'h0, 32'h0, "we0_r3");
    rd(5'd3, 32'h0, "r3_unchanged");
    wr(5'd3, 32'hAAAA5555);
    rd(5'd3, 32'hAAAA5555, "r3_written");

    // Back-to-back writes to one index.
    step(1'b1, 1'b1, 5'd12, 32'h1, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 32'h1, 32'h1, "b2b_1");
    step(1'b1, 1'b1, 5'd12, 32'h2, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 32'h2, 32'h2, "b2b_2");
    step(1'b1, 1'b1, 5'd12, 32'h3, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 32'h3, 32'h3, "b2b_3");
    rd(5'd12, 32'h3, "b2b_last");

    // Fill, reset mid-run, then a single write.
    for (int i = 1; i < REG_COUNT; i++) wr(reg_addr_t'(i), data_t'(i));
    rd(5'd1, 32'h1, "fill_r1");
    rd(5'd31, 32'h1F, "fill_r31");
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd17, 1'b1, 5'd30, 1'b1, 32'h11, 32'h1E, "fill_r17_r30");
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b1, 5'd31, 1'b1, 32'h0, 32'h0, "mid_rst");
    for (int i = 0; i < REG_COUNT; i++) rd(reg_addr_t'(i), 32'h0, "post_rst");
    wr(5'd31, 32'h31);
    for (int i = 0; i < REG_COUNT; i++)
      rd(reg_addr_t'(i), (i == 31) ? 32'h31 : 32'h0, "post_wr31");

    @(posedge clk);
    #1;
    chk = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters: none; widths come from shared bus constants (REG_ADDR_BUS = 5 bits, DATA_BUS = 32 bits).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 read_en_1  input  1  read port 1 enable (from ID register-address generation).
REQ-005 read_addr_1  input  5  read port 1 register index.
REQ-006 read_data_1  output  32  read port 1 data.
REQ-007 read_en_2  input  1  read port 2 enable.
REQ-008 read_addr_2  input  5  read port 2 register index.
REQ-009 read_data_2  output  32  read port 2 data.
REQ-010 write_en  input  1  write enable (from WB stage).
REQ-011 write_addr  input  5  write register index.
REQ-012 write_data  input  32  write data.

Function
REQ-013 Storage SHALL be 32 registers x 32 bits, index 0..31.
REQ-014 Register 0 SHALL always read as 0x00000000; writes to index 0 SHALL be discarded.
REQ-015 Write SHALL commit on rising clk edge when rst=1, write_en=1, write_addr!=0; no other register changes.
REQ-016 Reads SHALL be combinational (zero-cycle latency) from current storage.
REQ-017 read_data_N SHALL be 0 when read_en_N=0, regardless of read_addr_N.
REQ-018 Bypass: when read_en_N=1, write_en=1, write_addr=read_addr_N, write_addr!=0, read_data_N SHALL equal write_data in the same cycle.
REQ-019 Both ports SHALL operate independently; same address on both ports SHALL return identical data, including under bypass.
REQ-020 Priority per port: rst low -> 0; else read_en_N=0 -> 0; else addr 0 -> 0; else bypass hit -> write_data; else stored value.
REQ-021 Write with write_en=0 SHALL leave storage unchanged regardless of write_addr/write_data.
REQ-022 Back-to-back writes to the same index on consecutive cycles SHALL leave the last value; intermediate reads see each value per REQ-016/REQ-018.

Reset
REQ-023 When rst=0 at a rising edge, all 32 registers SHALL clear to 0x00000000.
REQ-024 While rst=0, read_data_1 and read_data_2 SHALL be 0 and writes SHALL be ignored, including a write present in the reset cycle.
REQ-025 Reset asserted mid-sequence SHALL discard all prior contents; first write after rst returns to 1 commits normally.

Structure
REQ-026 REG_ADDR_BUS, DATA_BUS, REG_COUNT (32) and ZERO_REG_ADDR (0) SHALL live in the shared bus constants include; no local width literals.
REQ-027 No sub-module; storage array, write logic and two identical read/bypass muxes SHALL be inline in reg_file.

Verification
REQ-028 Reset: hold rst=0 two cycles with write_en=1, addr 5, data 0xDEADBEEF -> release, read addr 5 en=1 -> 0x00000000.
REQ-029 Write/read: write 0x12345678 to r8, next cycle read port1 r8, port2 r8 -> both 0x12345678; read_en_2=0 -> port2 0.
REQ-030 Zero register: write 0xFFFFFFFF to r0, next cycle read r0 on both ports -> 0x00000000; same-cycle read of r0 during that write -> 0x00000000 (no bypass).
REQ-031 Bypass: r9 holds 0x1; same cycle write_en=1 r9 data 0xCAFEF00D, read port1 r9 -> 0xCAFEF00D combinationally; port2 r10 -> r10 stored value; next cycle r9 -> 0xCAFEF00D.
REQ-032 Write-enable gating: write_en=0, addr 3, data 0xAAAA5555 -> r3 unchanged (0 after reset); then write_en=1 -> r3 = 0xAAAA5555.
REQ-033 Reset mid-run: fill r1..r31 with index value, assert rst=0 one cycle -> every register reads 0; write r31=0x31 after release -> reads 0x00000031, others 0.
